fifo_nibble_packer: RTL and testbench



---
 rtl/fifo_nibble_packer_if.sv | 39 +++
 rtl/fifo_nibble_packer.sv | 118 +++++++++++
 tb/tb_fifo_nibble_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_nibble_packer_if.sv
// Read-port and byte-output bundle for the nibble packer.
// The master modport is the packer; the slave modport is the FIFO/consumer environment.
interface fifo_nibble_packer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                      fifo_empty;
    logic [DATA_WIDTH-1:0]     fifo_rdata;
    logic                      fifo_rinc;
    logic [2*DATA_WIDTH-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_partial;
    logic [7:0]                byte_count;
    logic                      busy;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  out_ready,
        output fifo_rinc,
        output out_data,
        output out_valid,
        output out_partial,
        output byte_count,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output out_ready,
        input  fifo_rinc,
        input  out_data,
        input  out_valid,
        input  out_partial,
        input  byte_count,
        input  busy
    );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Drains nibbles from the async FIFO read port and packs pairs into bytes, low nibble first.
// A half-filled byte is flushed as a flagged partial byte once the FIFO stays dry long enough.
module fifo_nibble_packer #(
    parameter int DATA_WIDTH   = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_nibble_packer_if.master bus
);
    localparam int BYTE_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam bit FLUSH_EN = (FLUSH_CYCLES != 0);
    localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_LO,
        ST_LO_CAP,
        ST_HI,
        ST_HI_CAP,
        ST_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [BYTE_W-1:0]       out_data_q, out_data_d;
    logic                    out_partial_q, out_partial_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [7:0]              byte_count_q, byte_count_d;
    logic                    pop;

    always_comb begin
        state_d       = state_q;
        lo_d          = lo_q;
        flush_cnt_d   = flush_cnt_q;
        out_data_d    = out_data_q;
        out_partial_d = out_partial_q;
        byte_count_d  = byte_count_q;
        pop           = 1'b0;

        case (state_q)
            ST_LO: begin
                if (!bus.fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_LO_CAP;
                end
            end
            ST_LO_CAP: begin
                lo_d        = bus.fifo_rdata;
                flush_cnt_d = '0;
                state_d     = ST_HI;
            end
            // A nibble arriving on the flush cycle wins over the flush.
            ST_HI: begin
                if (!bus.fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_HI_CAP;
                end else if (FLUSH_EN && (flush_cnt_q == FLUSH_LAST)) begin
                    out_data_d    = {{DATA_WIDTH{1'b0}}, lo_q};
                    out_partial_d = 1'b1;
                    state_d       = ST_OUT;
                end else if (FLUSH_EN) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_HI_CAP: begin
                out_data_d    = {bus.fifo_rdata, lo_q};
                out_partial_d = 1'b0;
                state_d       = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    byte_count_d = byte_count_q + 8'd1;
                    state_d      = ST_LO;
                end
            end
            default: begin
                state_d = ST_LO;
            end
        endcase

        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LO;
            lo_q          <= '0;
            flush_cnt_q   <= '0;
            out_data_q    <= '0;
            out_partial_q <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            byte_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            lo_q          <= lo_d;
            flush_cnt_q   <= flush_cnt_d;
            out_data_q    <= out_data_d;
            out_partial_q <= out_partial_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            byte_count_q  <= byte_count_d;
        end
    end

    // The pop strobe is masked by reset so the FIFO never loses a word to a discarded capture.
    assign bus.fifo_rinc   = pop && !rst;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_partial = out_partial_q;
    assign bus.byte_count  = byte_count_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Self-checking bench: a queue-based FIFO model feeds the packer and a queue of expected bytes
// (built from the pushed nibble order) is compared at every output handshake.
module tb_fifo_nibble_packer;
    localparam int DW = 4;
    localparam int FC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_nibble_packer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_nibble_packer #(
        .DATA_WIDTH  (DW),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [8:0]    exp_bytes[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            step;
    int            first_valid_step;
    int            rinc_count;
    int            hs_total = 0;
    logic [7:0]    exp_count = 8'd0;
    bit            prev_stall = 1'b0;
    logic [7:0]    prev_data = 8'd0;
    logic          prev_partial = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive at the falling edge, check while settled, update the FIFO model after the rising edge.
    task automatic applyStimulus(input bit force_empty, input bit ready);
        bit         pop;
        bit         hs;
        logic [8:0] e;
        @(negedge clk);
        bus.fifo_empty = force_empty || (fifo_q.size() == 0);
        bus.out_ready  = ready;
        #1;
        checkOutput("rinc_and_empty", 32'(bus.fifo_rinc & bus.fifo_empty), 32'd0);
        checkOutput("rinc_in_out", 32'(bus.fifo_rinc & bus.out_valid), 32'd0);
        checkOutput("byte_count", 32'(bus.byte_count), 32'(exp_count));
        if (rst) checkOutput("rinc_in_reset", 32'(bus.fifo_rinc), 32'd0);
        if (bus.out_valid) checkOutput("busy_in_out", 32'(bus.busy), 32'd1);
        if (prev_stall) begin
            checkOutput("valid_hold", 32'(bus.out_valid), 32'd1);
            checkOutput("data_hold", 32'(bus.out_data), 32'(prev_data));
            checkOutput("partial_hold", 32'(bus.out_partial), 32'(prev_partial));
        end
        pop = bus.fifo_rinc;
        hs  = bus.out_valid && bus.out_ready && !rst;
        if (pop) rinc_count++;
        if (bus.out_valid && first_valid_step < 0) first_valid_step = step;
        if (hs) begin
            hs_total++;
            if (exp_bytes.size() == 0) begin
                checkOutput("unexpected_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_bytes.pop_front();
                checkOutput("out_data", 32'(bus.out_data), 32'(e[7:0]));
                checkOutput("out_partial", 32'(bus.out_partial), 32'(e[8]));
            end
            exp_count = exp_count + 8'd1;
        end
        prev_stall   = bus.out_valid && !bus.out_ready && !rst;
        prev_data    = bus.out_data;
        prev_partial = bus.out_partial;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_count  = 8'd0;
            prev_stall = 1'b0;
            exp_bytes.delete();
        end
        if (pop && fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
        step++;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        checkOutput({tag, "_partial"}, 32'(bus.out_partial), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_byte_count"}, 32'(bus.byte_count), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_rinc"}, 32'(bus.fifo_rinc), 32'd0);
    endtask

    task automatic refillPairs();
        logic [DW-1:0] n0;
        logic [DW-1:0] n1;
        if (fifo_q.size() < 4) begin
            n0 = DW'($urandom);
            n1 = DW'($urandom);
            fifo_q.push_back(n0);
            fifo_q.push_back(n1);
            exp_bytes.push_back({1'b0, n1, n0});
        end
    endtask

    task automatic startTest();
        step             = 0;
        first_valid_step = -1;
        rinc_count       = 0;
    endtask

    initial begin
        int gate_run;
        int hs_base;
        bit gate;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        checkResetValues("reset");
        applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        checkResetValues("reset2");

        // Basic pair, consumer always ready
        startTest();
        fifo_q = '{4'h3, 4'hA};
        exp_bytes.push_back({1'b0, 8'hA3});
        repeat (8) applyStimulus(1'b0, 1'b1);
        checkOutput("a_rinc_pulses", 32'(rinc_count), 32'd2);
        checkOutput("a_valid_cycle", 32'(first_valid_step), 32'd4);
        checkOutput("a_byte_count", 32'(bus.byte_count), 32'd1);

        // Back-pressure with more data waiting behind the stalled byte
        startTest();
        fifo_q = '{4'h3, 4'hA};
        exp_bytes.push_back({1'b0, 8'hA3});
        for (int i = 0; i < 14; i++) begin
            if (i == 5) begin
                fifo_q.push_back(4'h1);
                fifo_q.push_back(4'h2);
                exp_bytes.push_back({1'b0, 8'h21});
            end
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("b_rinc_while_stalled", 32'(rinc_count), 32'd2);
        checkOutput("b_valid_stalled", 32'(bus.out_valid), 32'd1);
        repeat (12) applyStimulus(1'b0, 1'b1);
        checkOutput("b_rinc_total", 32'(rinc_count), 32'd4);
        checkOutput("b_byte_count", 32'(bus.byte_count), 32'd3);

        // Single nibble, FIFO stays dry: partial flush
        startTest();
        fifo_q = '{4'h5};
        exp_bytes.push_back({1'b1, 8'h05});
        repeat (24) applyStimulus(1'b0, 1'b1);
        checkOutput("flush_valid_cycle", 32'(first_valid_step), 32'(1 + 1 + FC));
        checkOutput("flush_byte_seen", 32'(exp_bytes.size()), 32'd0);

        // Second nibble lands exactly on the flush cycle: pop wins
        startTest();
        fifo_q = '{4'h5};
        exp_bytes.push_back({1'b0, 8'h75});
        for (int i = 0; i < 26; i++) begin
            if (i == 1 + FC) fifo_q.push_back(4'h7);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("race_valid_cycle", 32'(first_valid_step), 32'(1 + FC + 2));
        checkOutput("race_byte_seen", 32'(exp_bytes.size()), 32'd0);

        // Reset while holding a low nibble in HI
        startTest();
        fifo_q = '{4'hF};
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("hi_busy_before_reset", 32'(bus.busy), 32'd1);
        fifo_q.push_back(4'hE);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        fifo_q.delete();
        checkResetValues("mid_reset");
        fifo_q = '{4'h1, 4'h2};
        exp_bytes.push_back({1'b0, 8'h21});
        repeat (8) applyStimulus(1'b0, 1'b1);
        checkOutput("post_reset_byte_seen", 32'(exp_bytes.size()), 32'd0);
        checkOutput("post_reset_count", 32'(bus.byte_count), 32'd1);

        // Random empty gating and back-pressure; gaps stay shorter than the flush timeout
        startTest();
        gate_run = 0;
        hs_base  = hs_total;
        for (int i = 0; i < 2000; i++) begin
            refillPairs();
            gate = 1'b0;
            if (gate_run < 6 && $urandom_range(0, 2) == 0) begin
                gate = 1'b1;
                gate_run++;
            end else begin
                gate_run = 0;
            end
            applyStimulus(gate, ($urandom_range(0, 3) != 0));
        end
        checkOutput("random_progress", 32'(hs_total - hs_base > 100), 32'd1);

        // Byte counter wrap
        rst = 1'b1;
        fifo_q.delete();
        applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        checkResetValues("wrap_reset");
        hs_base = hs_total;
        for (int i = 0; i < 3000 && (hs_total - hs_base) < 256; i++) begin
            refillPairs();
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("wrap_hs_256", 32'(hs_total - hs_base), 32'd256);
        checkOutput("count_after_256", 32'(bus.byte_count), 32'd0);
        for (int i = 0; i < 20 && (hs_total - hs_base) < 257; i++) begin
            refillPairs();
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("wrap_hs_257", 32'(hs_total - hs_base), 32'd257);
        checkOutput("count_after_257", 32'(bus.byte_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
